// File: rtl/fc_layer_serializer_pkg.sv
// rtl/fc_layer_serializer_pkg.sv - shared state encoding for fc-layer control FSMs
package fc_layer_serializer_pkg;

  typedef enum logic {
    eIDLE = 1'b0,
    eSEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/fc_layer_serializer_if.sv
// rtl/fc_layer_serializer_if.sv - vector-in / word-out handshake bundle of the serializer
interface fc_layer_serializer_if #(
  parameter int WORD_SIZE    = 16,
  parameter int LAYER_HEIGHT = 2
);

  logic                                    valid_i;
  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]  data_i;
  logic                                    yumi_o;
  logic                                    full_i;
  logic                                    wen_o;
  logic signed [WORD_SIZE-1:0]             data_o;
  logic                                    last_o;
  logic                                    busy_o;

  modport slave (
    input  valid_i, data_i, full_i,
    output yumi_o, wen_o, data_o, last_o, busy_o
  );

  modport master (
    output valid_i, data_i, full_i,
    input  yumi_o, wen_o, data_o, last_o, busy_o
  );

endinterface

// File: rtl/fc_layer_serializer_index_counter.sv
// rtl/fc_layer_serializer_index_counter.sv - word index counter wrapping at LAYER_HEIGHT-1
module serializer_index_counter #(
  parameter int LAYER_HEIGHT = 2,
  parameter int IW           = $clog2(LAYER_HEIGHT + 1)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          en,
  input  logic          clr,
  output logic [IW-1:0] count,
  output logic          tc
);

  localparam logic [IW-1:0] LAST = IW'(LAYER_HEIGHT - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + IW'(1);
    end
  end

endmodule

// File: rtl/fc_layer_serializer.sv
// rtl/fc_layer_serializer.sv - takes one activation vector, writes it word-by-word
// into the next layer's FIFO with optional ReLU.
module fc_layer_serializer
  import fc_layer_serializer_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int LAYER_HEIGHT = 2,
  parameter int RELU_EN      = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  fc_layer_serializer_if.slave  bus
);

  localparam int IW = $clog2(LAYER_HEIGHT + 1);

  ser_state_t                             ps, ns;
  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] buffer;
  logic [IW-1:0]                          index;
  logic                                   tc;
  logic                                   cnt_en, cnt_clr, load;
  logic [WORD_SIZE-1:0]                   word, word_out;
  logic                                   yumi, wen, last, busy;

  serializer_index_counter #(
    .LAYER_HEIGHT (LAYER_HEIGHT),
    .IW           (IW)
  ) u_index (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en        (cnt_en),
    .clr       (cnt_clr),
    .count     (index),
    .tc        (tc)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ps     <= eIDLE;
      buffer <= '0;
    end else begin
      ps <= ns;
      if (load) begin
        buffer <= bus.data_i;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < LAYER_HEIGHT; i++) begin
      if (index == IW'(i)) begin
        word = buffer[i];
      end
    end
  end

  // ReLU looks at the sign bit only; positive words pass untouched.
  assign word_out = ((RELU_EN != 0) && word[WORD_SIZE-1]) ? '0 : word;

  // Outputs are gated by reset so nothing handshakes while reset is held.
  always_comb begin
    ns      = ps;
    yumi    = 1'b0;
    wen     = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    load    = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    if (reset_n_i) begin
      case (ps)
        eIDLE: begin
          yumi = bus.valid_i;
          if (bus.valid_i) begin
            load    = 1'b1;
            cnt_clr = 1'b1;
            ns      = eSEND;
          end
        end
        eSEND: begin
          busy   = 1'b1;
          wen    = !bus.full_i;
          last   = tc;
          cnt_en = wen;
          if (wen && tc) begin
            if (bus.valid_i) begin
              yumi = 1'b1;
              load = 1'b1;
            end else begin
              ns = eIDLE;
            end
          end
        end
        default: ns = eIDLE;
      endcase
    end
  end

  assign bus.yumi_o = yumi;
  assign bus.wen_o  = wen;
  assign bus.last_o = last;
  assign bus.busy_o = busy;
  assign bus.data_o = busy ? word_out : '0;

endmodule
